// File: rtl/dist_filter_pkg.sv
// Shared state encoding, parameter defaults and width helper for the distance filter.
package dist_filter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        STALE = 2'd2
    } state_t;

    localparam int unsigned MAX_DIST_DEF  = 50;
    localparam int unsigned JUMP_LIM_DEF  = 15;
    localparam int unsigned REJ_LIM_DEF   = 3;
    localparam int unsigned STALE_LIM_DEF = 10;

    function automatic int unsigned sum_width(input int unsigned depth);
        return 6 + $clog2(depth);
    endfunction

endpackage

// File: rtl/dist_ring_sum.sv
// DEPTH-entry sample ring with write pointer and running sum.
module dist_ring_sum #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SW    = 8
) (
    input  logic          clk_20Hz,
    input  logic          rst,
    input  logic          write,
    input  logic          seed,
    input  logic [5:0]    data,
    output logic [SW-1:0] sum
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [5:0]    ring [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [SW-1:0] sum_q;

    // sum is the running total with this tick's write or seed already applied,
    // so the caller can register its rounded mean with single-tick latency.
    always_comb begin
        sum = sum_q;
        if (seed) begin
            sum = SW'(data) << PW;
        end else if (write) begin
            sum = sum_q + SW'(data) - SW'(ring[wr_ptr]);
        end
    end

    always_ff @(posedge clk_20Hz) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ring[i] <= 6'd0;
            end
            wr_ptr <= '0;
            sum_q  <= '0;
        end else begin
            sum_q <= sum;
            if (seed) begin
                for (int i = 0; i < DEPTH; i++) begin
                    ring[i] <= data;
                end
                wr_ptr <= '0;
            end else if (write) begin
                ring[wr_ptr] <= data;
                wr_ptr       <= wr_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/distance_filter.sv
// Clamp, spike-reject and average the ultrasonic distance once per control tick.
// Optional jump-window rejection is enabled by defining DIST_FILTER_OUTLIER_EN.
module distance_filter
    import dist_filter_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_DIST  = MAX_DIST_DEF,
    parameter int unsigned JUMP_LIM  = JUMP_LIM_DEF,
    parameter int unsigned REJ_LIM   = REJ_LIM_DEF,
    parameter int unsigned STALE_LIM = STALE_LIM_DEF
) (
    input  logic       clk_20Hz,
    input  logic       rst,
    input  logic [5:0] raw_dist,
    input  logic       raw_valid,
    output logic [5:0] dist_out,
    output logic       dist_valid,
    output logic       stale,
    output logic [7:0] reject_cnt
);

    localparam int unsigned SW = sum_width(DEPTH);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned MW = $clog2(STALE_LIM + 1);
    localparam logic [5:0]    MAX_V     = 6'(MAX_DIST);
    localparam logic [MW-1:0] MISS_LAST = MW'(STALE_LIM - 1);

    state_t        state;
    logic [MW-1:0] miss_cnt;
    logic          has_sample;
    logic [5:0]    sample;
    logic          ring_write;
    logic          ring_seed;
    logic [SW-1:0] sum;
    logic [SW-1:0] rounded;

    assign has_sample = raw_valid && (raw_dist != 6'd0);
    assign sample     = (raw_dist > MAX_V) ? MAX_V : raw_dist;
    assign rounded    = sum + SW'(DEPTH / 2);

`ifdef DIST_FILTER_OUTLIER_EN
    localparam int unsigned RW = $clog2(REJ_LIM + 1);
    localparam logic [RW-1:0] RUN_LAST = RW'(REJ_LIM - 1);

    logic [RW-1:0] rej_run;
    logic [5:0]    jump;
    logic          in_window;
    logic          do_reject;

    assign jump      = (sample >= dist_out) ? (sample - dist_out) : (dist_out - sample);
    assign in_window = 32'(jump) <= JUMP_LIM;
    assign do_reject = (state == TRACK) && has_sample && !in_window && (rej_run < RUN_LAST);
`else
    logic unused_limits;
    assign unused_limits = (JUMP_LIM != 0) ^ (REJ_LIM != 0);
`endif

    // Outside TRACK any sample reseeds; inside TRACK an out-of-window sample
    // that has used up its reject run also reseeds.
    always_comb begin
        ring_write = 1'b0;
        ring_seed  = 1'b0;
        if (has_sample) begin
            if (state != TRACK) begin
                ring_seed = 1'b1;
`ifdef DIST_FILTER_OUTLIER_EN
            end else if (in_window) begin
                ring_write = 1'b1;
            end else if (!do_reject) begin
                ring_seed = 1'b1;
`else
            end else begin
                ring_write = 1'b1;
`endif
            end
        end
    end

    dist_ring_sum #(
        .DEPTH (DEPTH),
        .SW    (SW)
    ) u_ring (
        .clk_20Hz (clk_20Hz),
        .rst      (rst),
        .write    (ring_write),
        .seed     (ring_seed),
        .data     (sample),
        .sum      (sum)
    );

    always_ff @(posedge clk_20Hz) begin
        if (rst) begin
            state      <= IDLE;
            miss_cnt   <= '0;
            dist_out   <= 6'd0;
            dist_valid <= 1'b0;
            stale      <= 1'b0;
        end else begin
            dist_out <= rounded[SW-1:PW];
            if (ring_seed) begin
                state      <= TRACK;
                miss_cnt   <= '0;
                dist_valid <= 1'b1;
                stale      <= 1'b0;
            end else if (ring_write) begin
                miss_cnt <= '0;
            end else if (state == TRACK && !has_sample) begin
                miss_cnt <= miss_cnt + MW'(1);
                if (miss_cnt == MISS_LAST) begin
                    state      <= STALE;
                    dist_valid <= 1'b0;
                    stale      <= 1'b1;
                end
            end
        end
    end

`ifdef DIST_FILTER_OUTLIER_EN
    always_ff @(posedge clk_20Hz) begin
        if (rst) begin
            rej_run    <= '0;
            reject_cnt <= 8'd0;
        end else if (ring_seed || ring_write) begin
            rej_run <= '0;
        end else if (do_reject) begin
            rej_run <= rej_run + RW'(1);
            if (reject_cnt != 8'hFF) begin
                reject_cnt <= reject_cnt + 8'd1;
            end
        end
    end
`else
    assign reject_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_distance_filter.sv
// Self-checking bench for distance_filter against a window-queue reference model.
module tb_distance_filter;

    localparam int D    = 4;
    localparam int MAXD = 50;
    localparam int JL   = 15;
    localparam int RL   = 3;
    localparam int SL   = 10;

    logic       clk_20Hz = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] raw_dist = 6'd0;
    logic       raw_valid = 1'b0;
    logic [5:0] dist_out;
    logic       dist_valid;
    logic       stale;
    logic [7:0] reject_cnt;

    distance_filter dut (
        .clk_20Hz   (clk_20Hz),
        .rst        (rst),
        .raw_dist   (raw_dist),
        .raw_valid  (raw_valid),
        .dist_out   (dist_out),
        .dist_valid (dist_valid),
        .stale      (stale),
        .reject_cnt (reject_cnt)
    );

    always #5 clk_20Hz = ~clk_20Hz;

    int total = 0;
    int bad   = 0;

    // Reference model: 0=idle 1=tracking 2=stale, window held as a FIFO queue
    int m_win[$];
    int m_state, m_out, m_valid, m_stale, m_rejcnt, m_miss;
`ifdef DIST_FILTER_OUTLIER_EN
    int m_run;
`endif

    function automatic int win_avg();
        int s = 0;
        foreach (m_win[i]) s += m_win[i];
        return (s + D / 2) / D;
    endfunction

    task automatic model_reset();
        m_win.delete();
        m_state = 0; m_out = 0; m_valid = 0; m_stale = 0; m_rejcnt = 0; m_miss = 0;
`ifdef DIST_FILTER_OUTLIER_EN
        m_run = 0;
`endif
    endtask

    task automatic model_seed(input int s);
        m_win.delete();
        repeat (D) m_win.push_back(s);
        m_miss = 0;
`ifdef DIST_FILTER_OUTLIER_EN
        m_run = 0;
`endif
        m_state = 1;
    endtask

    task automatic model_accept(input int s);
        m_win.push_back(s);
        void'(m_win.pop_front());
        m_miss = 0;
`ifdef DIST_FILTER_OUTLIER_EN
        m_run = 0;
`endif
    endtask

    task automatic model_tick(input bit v, input int raw);
        bit smp;
        int s;
`ifdef DIST_FILTER_OUTLIER_EN
        int d;
`endif
        smp = v && (raw != 0);
        s = (raw > MAXD) ? MAXD : raw;
        if (m_state != 1) begin
            if (smp) model_seed(s);
        end else if (smp) begin
`ifdef DIST_FILTER_OUTLIER_EN
            d = (s > m_out) ? s - m_out : m_out - s;
            if (d <= JL) model_accept(s);
            else if (m_run < RL - 1) begin
                m_run++;
                if (m_rejcnt < 255) m_rejcnt++;
            end else model_seed(s);
`else
            model_accept(s);
`endif
        end else begin
            m_miss++;
            if (m_miss == SL) m_state = 2;
        end
        m_valid = (m_state == 1);
        m_stale = (m_state == 2);
        m_out   = (m_state == 0) ? 0 : win_avg();
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".dist_out"},   {2'b00, dist_out},   8'(m_out));
        check({tag, ".dist_valid"}, {7'd0, dist_valid},  8'(m_valid));
        check({tag, ".stale"},      {7'd0, stale},       8'(m_stale));
        check({tag, ".reject_cnt"}, reject_cnt,          8'(m_rejcnt));
    endtask

    task automatic resetPulse();
        rst = 1'b1;
        raw_valid = 1'b0;
        @(posedge clk_20Hz);
        #1;
        rst = 1'b0;
        model_reset();
        checkOutput("reset");
    endtask

    task automatic applyStimulus(input bit v, input int raw, input string tag);
        raw_valid = v;
        raw_dist  = 6'(raw);
        @(posedge clk_20Hz);
        #1;
        model_tick(v, raw);
        checkOutput(tag);
    endtask

    initial begin
        int r, t;
        model_reset();
        resetPulse();

        applyStimulus(1, 20, "first_seed");
        check("first_seed.const", {2'b00, dist_out}, 8'd20);
        repeat (3) applyStimulus(1, 20, "steady20");
        applyStimulus(1, 24, "spike24");
        repeat (4) applyStimulus(1, 20, "resteady20");
        repeat (3) applyStimulus(1, 45, "jump45");

        resetPulse();
        applyStimulus(1, 63, "clamp63");
        check("clamp63.const", {2'b00, dist_out}, 8'd50);
        applyStimulus(1, 0, "zero_is_miss");
        applyStimulus(0, 40, "invalid_is_miss");

        resetPulse();
        repeat (4) applyStimulus(1, 30, "steady30");
        repeat (SL) applyStimulus(0, 0, "miss_to_stale");
        applyStimulus(0, 0, "stale_hold");
        applyStimulus(1, 12, "stale_exit");

        // Build up rejects, then reset in the middle of tracking
        resetPulse();
        repeat (4) applyStimulus(1, 20, "pre_rej");
        repeat (3) applyStimulus(1, 45, "rej_a");
        repeat (3) applyStimulus(1, 10, "rej_b");
        applyStimulus(1, 40, "rej_c");
        resetPulse();
        applyStimulus(1, 33, "post_reset_seed");

        // Alternating far levels drive reject_cnt into saturation
        for (int i = 0; i < 135; i++) begin
            repeat (3) applyStimulus(1, 50, "sat_hi");
            repeat (3) applyStimulus(1, 10, "sat_lo");
        end

        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(99));
            if (r < 1) resetPulse();
            else if (r < 3) repeat (SL + 1) applyStimulus(0, 0, "rnd_burst_miss");
            else if (r < 15) applyStimulus(0, int'($urandom_range(63)), "rnd_miss");
            else if (r < 20) applyStimulus(1, 0, "rnd_zero");
            else if (r < 35) applyStimulus(1, int'($urandom_range(63, 1)), "rnd_any");
            else begin
                t = m_out + int'($urandom_range(40)) - 20;
                if (t < 1) t = 1;
                if (t > 63) t = 63;
                applyStimulus(1, t, "rnd_near");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
